fb_arbiter: RTL and testbench

Double-buffered framebuffer controller between the VGA scan-out path and the image writer (camera/classifier preview). Owns the single-port pixel RAM: serves display pixel reads with absolute priority and fixed latency, and fills remaining cycles with writer transactions on a valid/ready port. Holds two frame banks. Display reads the front bank while the writer fills the back bank. A swap requested by the writer takes effect only at the display frame boundary, so no frame ever tears.

---
 rtl/fb_arbiter_pkg.sv | 26 ++
 rtl/fb_arbiter_if.sv | 43 ++++
 rtl/fb_bank_ctrl.sv | 53 +++++
 rtl/fb_arbiter.sv | 92 +++++++++
 tb/tb_fb_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_arbiter_pkg.sv
// Shared types and helpers for the double-buffered framebuffer arbiter.
// Pixel format, swap FSM state encoding and pixel-index arithmetic live here.
package fb_arbiter_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } bank_state_t;

  // Cycles from disp_req to disp_valid.
  localparam int DISP_LAT = 3;

  // Row-major pixel index; callers truncate to their index width.
  function automatic logic [31:0] pix_index(input logic [9:0] x,
                                            input logic [8:0] y,
                                            input int unsigned width);
    return 32'(y) * width + 32'(x);
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of display, writer and pixel-RAM signals around fb_arbiter.
// slave is the arbiter's view; master is the surrounding system (VGA, writer, RAM).
interface fb_arbiter_if #(
  parameter int PIX_W = 10
);
  import fb_arbiter_pkg::*;

  logic             disp_req;
  logic [9:0]       disp_x;
  logic [8:0]       disp_y;
  rgb_t             disp_rgb;
  logic             disp_valid;
  logic             frame_start;
  logic             wr_valid;
  logic             wr_ready;
  logic [9:0]       wr_x;
  logic [8:0]       wr_y;
  rgb_t             wr_rgb;
  logic             wr_frame_done;
  logic             swap_pending;
  logic             front_bank;
  logic [PIX_W:0]   mem_addr;
  logic             mem_we;
  rgb_t             mem_wdata;
  rgb_t             mem_rdata;

  modport slave (
    input  disp_req, disp_x, disp_y, frame_start,
    input  wr_valid, wr_x, wr_y, wr_rgb, wr_frame_done,
    input  mem_rdata,
    output disp_rgb, disp_valid, wr_ready, swap_pending, front_bank,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_x, disp_y, frame_start,
    output wr_valid, wr_x, wr_y, wr_rgb, wr_frame_done,
    output mem_rdata,
    input  disp_rgb, disp_valid, wr_ready, swap_pending, front_bank,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_bank_ctrl.sv
// Front/back bank swap FSM: a writer's swap request is held until the
// display frame boundary so a displayed frame never mixes two banks.
module fb_bank_ctrl
  import fb_arbiter_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic wr_frame_done,
  input  logic frame_start,
  output logic front_bank,
  output logic swap_pending,
  output logic idle
);

  bank_state_t state_reg, state_next;
  logic        front_bank_reg, front_bank_next;

  always_comb begin
    state_next      = state_reg;
    front_bank_next = front_bank_reg;
    case (state_reg)
      IDLE: begin
        if (wr_frame_done) begin
          // Request landing exactly on the boundary swaps without waiting.
          if (frame_start) front_bank_next = ~front_bank_reg;
          else             state_next      = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          front_bank_next = ~front_bank_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      front_bank_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      front_bank_reg <= front_bank_next;
    end
  end

  assign front_bank   = front_bank_reg;
  assign swap_pending = (state_reg == PENDING);
  assign idle         = (state_reg == IDLE);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port pixel RAM arbiter: display reads win every cycle with fixed
// latency, writer transactions fill the remaining cycles into the back bank.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input logic          CLOCK_50,
  input logic          reset_n,
  fb_arbiter_if.slave  bus
);

  localparam int PIX_W  = $clog2(WIDTH * HEIGHT);
  localparam int PIPE_W = DISP_LAT - 1;

  logic             front_bank;
  logic             swap_pending;
  logic             bank_idle;
  logic             disp_in_range;
  logic             wr_in_range;
  logic             wr_ready;
  logic             wr_fire;
  logic [PIX_W-1:0] disp_idx;
  logic [PIX_W-1:0] wr_idx;

  logic [PIPE_W-1:0] rd_valid_reg;
  logic [PIPE_W-1:0] rd_oor_reg;
  logic              disp_valid_reg;
  rgb_t              disp_rgb_reg;
  logic [PIX_W:0]    mem_addr_reg;
  logic              mem_we_reg;
  rgb_t              mem_wdata_reg;

  fb_bank_ctrl u_bank_ctrl (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .wr_frame_done (bus.wr_frame_done),
    .frame_start   (bus.frame_start),
    .front_bank    (front_bank),
    .swap_pending  (swap_pending),
    .idle          (bank_idle)
  );

  assign disp_in_range = (32'(bus.disp_x) < WIDTH) && (32'(bus.disp_y) < HEIGHT);
  assign wr_in_range   = (32'(bus.wr_x) < WIDTH) && (32'(bus.wr_y) < HEIGHT);
  assign disp_idx      = PIX_W'(pix_index(bus.disp_x, bus.disp_y, WIDTH));
  assign wr_idx        = PIX_W'(pix_index(bus.wr_x, bus.wr_y, WIDTH));

  // Combinational so a display request blocks the writer in the same cycle.
  assign wr_ready = reset_n & ~bus.disp_req & bank_idle;
  assign wr_fire  = bus.wr_valid & wr_ready;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg   <= '0;
      rd_oor_reg     <= '0;
      disp_valid_reg <= 1'b0;
      disp_rgb_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
    end else begin
      // Out-of-range reads travel the pipe as a flag so latency is unchanged.
      rd_valid_reg <= {rd_valid_reg[PIPE_W-2:0], bus.disp_req};
      rd_oor_reg   <= {rd_oor_reg[PIPE_W-2:0], ~disp_in_range};
      mem_we_reg   <= 1'b0;

      if (bus.disp_req) begin
        if (disp_in_range) mem_addr_reg <= {front_bank, disp_idx};
      end else if (wr_fire && wr_in_range) begin
        mem_addr_reg  <= {~front_bank, wr_idx};
        mem_we_reg    <= 1'b1;
        mem_wdata_reg <= bus.wr_rgb;
      end

      disp_valid_reg <= rd_valid_reg[PIPE_W-1];
      if (rd_valid_reg[PIPE_W-1])
        disp_rgb_reg <= rd_oor_reg[PIPE_W-1] ? '0 : bus.mem_rdata;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.front_bank   = front_bank;
  assign bus.swap_pending = swap_pending;
  assign bus.disp_valid   = disp_valid_reg;
  assign bus.disp_rgb     = disp_rgb_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_we       = mem_we_reg;
  assign bus.mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port pixel RAM.
// RAM preload: word a holds 0x5C0000 | a, so expected reads are hand-derivable.
module tb_fb_arbiter;
  import fb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic ram_load;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fb_arbiter_if #(.PIX_W(10)) bus ();

  fb_arbiter #(
    .WIDTH  (28),
    .HEIGHT (28)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  logic [23:0] ram [0:2047];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 24'h5C0000 | 24'(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues one display read now (cycle n) and checks cycles n+1..n+4.
  task automatic disp_read(input logic [9:0] x, input logic [8:0] y,
                           input logic [31:0] exp_rgb, input logic [31:0] exp_addr);
    bus.disp_req = 1'b1;
    bus.disp_x   = x;
    bus.disp_y   = y;
    cyc();
    bus.disp_req = 1'b0;
    #1;
    check("rd_addr", 32'(bus.mem_addr), exp_addr);
    check("rd_we", 32'(bus.mem_we), 32'd0);
    check("rd_valid_n1", 32'(bus.disp_valid), 32'd0);
    cyc(); #1;
    check("rd_valid_n2", 32'(bus.disp_valid), 32'd0);
    cyc(); #1;
    check("rd_valid_n3", 32'(bus.disp_valid), 32'd1);
    check("rd_rgb", 32'(bus.disp_rgb), exp_rgb);
    $display("read (%0d,%0d) -> %h", x, y, bus.disp_rgb);
    cyc(); #1;
    check("rd_valid_n4", 32'(bus.disp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_front"},  32'(bus.front_bank), 32'd0);
    check({tag, "_pend"},   32'(bus.swap_pending), 32'd0);
    check({tag, "_valid"},  32'(bus.disp_valid), 32'd0);
    check({tag, "_rgb"},    32'(bus.disp_rgb), 32'd0);
    check({tag, "_we"},     32'(bus.mem_we), 32'd0);
    check({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"},  32'(bus.mem_wdata), 32'd0);
    check({tag, "_wready"}, 32'(bus.wr_ready), 32'd0);
  endtask

  initial begin
    reset_n           = 1'b0;
    ram_load          = 1'b1;
    bus.disp_req      = 1'b0;
    bus.disp_x        = '0;
    bus.disp_y        = '0;
    bus.frame_start   = 1'b0;
    bus.wr_valid      = 1'b0;
    bus.wr_x          = '0;
    bus.wr_y          = '0;
    bus.wr_rgb        = '0;
    bus.wr_frame_done = 1'b0;

    cyc(); cyc(); #1;
    check_reset_outputs("rst");
    ram_load = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("post_rst_wready", 32'(bus.wr_ready), 32'd1);
    cyc();

    // Front bank 0 read of preloaded word 59.
    disp_read(10'd3, 9'd2, 32'h5C003B, 32'd59);

    // Write (3,2) into back bank 1, then swap and read it back.
    bus.wr_valid = 1'b1; bus.wr_x = 10'd3; bus.wr_y = 9'd2; bus.wr_rgb = 24'h112233;
    #1;
    check("w1_ready", 32'(bus.wr_ready), 32'd1);
    cyc();
    bus.wr_valid = 1'b0;
    #1;
    check("w1_we", 32'(bus.mem_we), 32'd1);
    check("w1_addr", 32'(bus.mem_addr), 32'd1083);
    check("w1_wdata", 32'(bus.mem_wdata), 32'h112233);
    cyc(); #1;
    check("w1_we_once", 32'(bus.mem_we), 32'd0);
    bus.wr_frame_done = 1'b1;
    cyc();
    bus.wr_frame_done = 1'b0;
    #1;
    check("sw1_pend", 32'(bus.swap_pending), 32'd1);
    check("sw1_wready", 32'(bus.wr_ready), 32'd0);
    check("sw1_front_old", 32'(bus.front_bank), 32'd0);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    #1;
    check("sw1_front", 32'(bus.front_bank), 32'd1);
    check("sw1_pend_clr", 32'(bus.swap_pending), 32'd0);
    check("sw1_wready", 32'(bus.wr_ready), 32'd1);
    disp_read(10'd3, 9'd2, 32'h112233, 32'd1083);

    // Ten back-to-back reads of (c,0) in bank 1 while a write to (5,1) waits.
    for (int c = 0; c < 14; c++) begin
      bus.disp_req = (c < 10);
      bus.disp_x   = 10'(c);
      bus.disp_y   = 9'd0;
      bus.wr_valid = (c <= 10);
      bus.wr_x     = 10'd5;
      bus.wr_y     = 9'd1;
      bus.wr_rgb   = 24'hABCDEF;
      #1;
      check("b2b_wready", 32'(bus.wr_ready), 32'(c >= 10));
      check("b2b_we", 32'(bus.mem_we), 32'(c == 11));
      if (c == 11) begin
        check("b2b_waddr", 32'(bus.mem_addr), 32'd33);
        check("b2b_wdata", 32'(bus.mem_wdata), 32'hABCDEF);
      end
      check("b2b_valid", 32'(bus.disp_valid), 32'(c >= 3 && c < 13));
      if (c >= 3 && c < 13) begin
        check("b2b_rgb", 32'(bus.disp_rgb), 32'h5C0400 + 32'(c - 3));
        $display("read (%0d,0) -> %h", c - 3, bus.disp_rgb);
      end
      cyc();
    end

    // Boundary pixel, then out-of-range reads: zero data, address untouched.
    disp_read(10'd27, 9'd27, 32'h5C070F, 32'd1807);
    disp_read(10'd28, 9'd0, 32'h000000, 32'd1807);
    disp_read(10'd0, 9'd28, 32'h000000, 32'd1807);
    bus.wr_valid = 1'b1; bus.wr_x = 10'd40; bus.wr_y = 9'd5; bus.wr_rgb = 24'hFFFFFF;
    #1;
    check("oor_w_ready", 32'(bus.wr_ready), 32'd1);
    cyc();
    bus.wr_valid = 1'b0;
    #1;
    check("oor_w_we", 32'(bus.mem_we), 32'd0);
    check("oor_w_addr", 32'(bus.mem_addr), 32'd1807);

    // Long pending swap: writer blocked for 50 cycles until frame_start.
    bus.wr_frame_done = 1'b1;
    #1;
    check("sw2_req_ready", 32'(bus.wr_ready), 32'd1);
    cyc();
    bus.wr_frame_done = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_x = 10'd1; bus.wr_y = 9'd1; bus.wr_rgb = 24'h0F0F0F;
    for (int k = 0; k < 50; k++) begin
      #1;
      check("sw2_pend", 32'(bus.swap_pending), 32'd1);
      check("sw2_wready", 32'(bus.wr_ready), 32'd0);
      check("sw2_we", 32'(bus.mem_we), 32'd0);
      check("sw2_front", 32'(bus.front_bank), 32'd1);
      cyc();
    end
    bus.wr_valid    = 1'b0;
    bus.frame_start = 1'b1;
    #1;
    check("sw2_fs_wready", 32'(bus.wr_ready), 32'd0);
    cyc();
    bus.frame_start = 1'b0;
    #1;
    check("sw2_front_new", 32'(bus.front_bank), 32'd0);
    check("sw2_pend_clr", 32'(bus.swap_pending), 32'd0);
    check("sw2_wready_back", 32'(bus.wr_ready), 32'd1);

    // frame_start with nothing pending does nothing.
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    #1;
    check("fs_only_front", 32'(bus.front_bank), 32'd0);
    check("fs_only_pend", 32'(bus.swap_pending), 32'd0);

    // Request and boundary together: immediate swap, never pending.
    bus.wr_frame_done = 1'b1;
    bus.frame_start   = 1'b1;
    cyc();
    bus.wr_frame_done = 1'b0;
    bus.frame_start   = 1'b0;
    #1;
    check("sw3_front", 32'(bus.front_bank), 32'd1);
    check("sw3_pend", 32'(bus.swap_pending), 32'd0);
    cyc(); #1;
    check("sw3_pend_later", 32'(bus.swap_pending), 32'd0);

    // Read issued one cycle before the swap completes from the old front bank.
    bus.wr_frame_done = 1'b1;
    cyc();
    bus.wr_frame_done = 1'b0;
    #1;
    check("sw4_pend", 32'(bus.swap_pending), 32'd1);
    bus.disp_req = 1'b1; bus.disp_x = 10'd5; bus.disp_y = 9'd1;
    cyc();
    bus.disp_req    = 1'b0;
    bus.frame_start = 1'b1;
    #1;
    check("sw4_rd_addr", 32'(bus.mem_addr), 32'd1057);
    cyc();
    bus.frame_start = 1'b0;
    #1;
    check("sw4_front", 32'(bus.front_bank), 32'd0);
    check("sw4_valid_n2", 32'(bus.disp_valid), 32'd0);
    cyc(); #1;
    check("sw4_valid_n3", 32'(bus.disp_valid), 32'd1);
    check("sw4_rgb_old_bank", 32'(bus.disp_rgb), 32'h5C0421);
    $display("read (5,1) -> %h", bus.disp_rgb);
    cyc();
    disp_read(10'd5, 9'd1, 32'hABCDEF, 32'd33);

    // Reset one cycle after a read request drops it and restores bank 0.
    bus.wr_frame_done = 1'b1;
    bus.frame_start   = 1'b1;
    cyc();
    bus.wr_frame_done = 1'b0;
    bus.frame_start   = 1'b0;
    #1;
    check("rst_pre_front", 32'(bus.front_bank), 32'd1);
    bus.disp_req = 1'b1; bus.disp_x = 10'd1; bus.disp_y = 9'd1;
    cyc();
    bus.disp_req = 1'b0;
    reset_n      = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rst_no_valid", 32'(bus.disp_valid), 32'd0);
      check("rst_front", 32'(bus.front_bank), 32'd0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
